// File: rtl/if_id_queue.sv
// if_id_queue
// -----------------------------------------------------------------------------
// A DEPTH-entry instruction queue between fetch and decode, followed by the
// output register that drives ID. Fetch can keep pushing while ID is stalled.
// ID receives a zero bubble whenever nothing is available. A flush empties the
// queue and the output register in one cycle.
//
// Handshake: a fetch beat transfers on a rising edge when if_valid && if_ready.
// if_ready is decoded only from the registered occupancy, so it has no
// combinational path from stall or flush. A beat that is dropped by a
// simultaneous flush is still consumed from fetch's point of view.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_valid/pc/inst  fetch beat in; if_ready = queue not full
//   stall             pipeline stall vector; only bit ID_STALL_BIT is used
//   flush             discard queued entries and the presented instruction
//   id_valid/pc/inst  output register presented to ID
//   fifo_count        queue occupancy (output register excluded)
//   fifo_full/empty   decoded from fifo_count
// -----------------------------------------------------------------------------
module if_id_queue #(
  parameter int ADDR_W       = 32,
  parameter int INST_W       = 32,
  parameter int DEPTH        = 4,
  parameter int STALL_W      = 6,
  parameter int ID_STALL_BIT = 2,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [INST_W-1:0]  if_inst,
  output logic               if_ready,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INST_W-1:0]  id_inst,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               fifo_full,
  output logic               fifo_empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic advance;
  logic push;
  logic pop_en;
  logic wr_en;
  logic bypass;
  logic [ENTRY_W-1:0] head;

  // Only the ID bit of the stall vector matters to this stage.
  logic stall_unused;
  assign stall_unused = ^stall;

  assign fifo_count = count;
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign if_ready   = !fifo_full;

  assign advance = !stall[ID_STALL_BIT];
  assign push    = if_valid && if_ready;
  assign head    = mem[rd_ptr];

  // With an empty queue and ID advancing, the fetch beat goes straight to the
  // output register so latency matches the old single-register stage.
  assign bypass = advance && fifo_empty && push;
  assign pop_en = !flush && advance && !fifo_empty;
  assign wr_en  = !flush && push && !bypass;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {if_pc, if_inst};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (wr_en && !pop_en) begin
        count <= count + CNT_W'(1);
      end else if (pop_en && !wr_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (advance) begin
      if (!fifo_empty) begin
        id_valid           <= 1'b1;
        {id_pc, id_inst}   <= head;
      end else if (push) begin
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_inst  <= if_inst;
      end else begin
        id_valid <= 1'b0;
        id_pc    <= '0;
        id_inst  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: directed scenarios plus a random phase, checked
// against a queue-based reference of what ID should see.
module tb_if_id_queue;

  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int DEPTH   = 4;
  localparam int STALL_W = 6;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int W       = ADDR_W + INST_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               if_valid = 1'b0;
  logic [ADDR_W-1:0]  if_pc    = '0;
  logic [INST_W-1:0]  if_inst  = '0;
  logic               if_ready;
  logic [STALL_W-1:0] stall    = '0;
  logic               flush    = 1'b0;
  logic               id_valid;
  logic [ADDR_W-1:0]  id_pc;
  logic [INST_W-1:0]  id_inst;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  if_id_queue dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_ready   (if_ready),
    .stall      (stall),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];      // accepted, not yet delivered, in FIFO order
  logic              m_valid = 1'b0;
  logic [ADDR_W-1:0] m_pc    = '0;
  logic [INST_W-1:0] m_inst  = '0;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".id_valid"},   64'(id_valid),   64'(m_valid));
    check({tag, ".id_pc"},      64'(id_pc),      64'(m_pc));
    check({tag, ".id_inst"},    64'(id_inst),    64'(m_inst));
    check({tag, ".fifo_count"}, 64'(fifo_count), 64'(exp_q.size()));
    check({tag, ".fifo_full"},  64'(fifo_full),  64'(exp_q.size() == DEPTH));
    check({tag, ".fifo_empty"}, 64'(fifo_empty), 64'(exp_q.size() == 0));
    check({tag, ".if_ready"},   64'(if_ready),   64'(exp_q.size() < DEPTH));
  endtask

  // Reference update at a clock edge using the inputs held across it.
  task automatic model_edge();
    logic [W-1:0] e;
    bit acc;
    acc = if_valid && (exp_q.size() < DEPTH);
    if (flush) begin
      exp_q.delete();
      m_valid = 1'b0; m_pc = '0; m_inst = '0;
    end else if (!stall[2]) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_valid = 1'b1; m_pc = e[W-1:INST_W]; m_inst = e[INST_W-1:0];
        if (acc) exp_q.push_back({if_pc, if_inst});
      end else if (acc) begin
        m_valid = 1'b1; m_pc = if_pc; m_inst = if_inst;
      end else begin
        m_valid = 1'b0; m_pc = '0; m_inst = '0;
      end
    end else if (acc) begin
      exp_q.push_back({if_pc, if_inst});
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input string tag, input bit v, input logic [ADDR_W-1:0] pc,
                       input bit id_stall, input bit fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = $urandom;
    stall    = 6'($urandom_range(0, 63));
    stall[2] = id_stall;
    flush    = fl;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset state, checked while reset is held.
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Bypass: each push appears on ID one cycle later, queue stays empty.
    cycle("bypass0", 1, 32'h00, 0, 0);
    cycle("bypass1", 1, 32'h04, 0, 0);
    cycle("bypass2", 1, 32'h08, 0, 0);
    cycle("bubble0", 0, 32'h0,  0, 0);

    // Stall while fetch runs ahead: four accepted, the rest refused.
    for (int i = 0; i < 6; i++) cycle("stall_fill", 1, 32'h10 + 32'(4 * i), 1, 0);
    for (int i = 0; i < 6; i++) cycle("drain", 0, 32'h0, 0, 0);

    // Flush with a simultaneous push: nothing survives.
    for (int i = 0; i < 3; i++) cycle("pre_flush", 1, 32'h30 + 32'(4 * i), 1, 0);
    cycle("flush", 1, 32'h40, 1, 1);
    for (int i = 0; i < 2; i++) cycle("post_flush", 0, 32'h0, 0, 0);
    cycle("resume", 1, 32'h80, 0, 0);
    cycle("after80", 0, 32'h0, 0, 0);

    // Wrap-around at a steady occupancy of two.
    cycle("wrap_fill", 1, 32'h100, 1, 0);
    cycle("wrap_fill", 1, 32'h104, 1, 0);
    for (int i = 0; i < 10; i++) cycle("wrap", 1, 32'h108 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 4; i++) cycle("wrap_drain", 0, 32'h0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(4 * i),
            $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
    end

    // Fill, then assert reset between edges: outputs clear immediately.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 32'h200 + 32'(4 * i), 1, 0);
    check("pre_rst.full_reached", 64'(fifo_full), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    m_valid = 1'b0; m_pc = '0; m_inst = '0;
    check_all("async_rst");
    if_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle("post_rst", 1'($urandom_range(0, 1)), 32'h300 + 32'(4 * i),
            $urandom_range(0, 1) == 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
